// File: rtl/win_reader.sv
// Raster scanner that streams every 3x3 neighbourhood of a frame from a
// three-row-wide frame-store port, one column fetch per accepted window.
module win_reader #(
    parameter int IMG_W = 180,
    parameter int IMG_H = 320,
    parameter int DW    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            finA,
    output logic [15:0]     a1,
    input  logic [DW-1:0]   M1d1,
    input  logic [DW-1:0]   M1d2,
    input  logic [DW-1:0]   M1d3,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [8:0]      win_row,
    output logic [7:0]      win_col,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, RUN, DONE} state_t;

    localparam logic [15:0] ROW_STEP = 16'(IMG_W);
    localparam logic [8:0]  LAST_ROW = 9'(IMG_H - 2);
    localparam logic [7:0]  LAST_COL = 8'(IMG_W - 2);

    state_t            state_q, state_d;
    logic              finA_q, finA_d;
    logic [15:0]       base_q, base_d;
    logic [7:0]        fcol_q, fcol_d;
    logic [9*DW-1:0]   win_q, win_d;
    logic              vld_q, vld_d;
    logic [8:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic              capture;

    // Drop the leftmost column and append the freshly read column on the right.
    function automatic logic [9*DW-1:0] shift_col(input logic [9*DW-1:0] w,
                                                  input logic [DW-1:0] top,
                                                  input logic [DW-1:0] mid,
                                                  input logic [DW-1:0] bot);
        return {bot, w[8*DW +: DW], w[7*DW +: DW],
                mid, w[5*DW +: DW], w[4*DW +: DW],
                top, w[2*DW +: DW], w[1*DW +: DW]};
    endfunction

    always_comb begin
        state_d = state_q;
        finA_d  = finA;
        base_d  = base_q;
        fcol_d  = fcol_q;
        win_d   = win_q;
        vld_d   = vld_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (finA && !finA_q) begin
                    state_d = PRIME0;
                    base_d  = '0;
                    fcol_d  = '0;
                    row_d   = 9'd1;
                end
            end
            PRIME0: begin
                capture = 1'b1;
                state_d = PRIME1;
            end
            PRIME1: begin
                capture = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (!vld_q) begin
                    capture = 1'b1;
                    vld_d   = 1'b1;
                    col_d   = 8'd1;
                end else if (win_ready) begin
                    if (col_q != LAST_COL) begin
                        capture = 1'b1;
                        col_d   = col_q + 8'd1;
                    end else begin
                        // End of a row band: re-prime the next band or finish.
                        vld_d  = 1'b0;
                        fcol_d = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = DONE;
                        end else begin
                            state_d = PRIME0;
                            row_d   = row_q + 9'd1;
                            base_d  = base_q + ROW_STEP;
                        end
                    end
                end
            end
            DONE: begin
                if (!finA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            win_d  = shift_col(win_q, M1d1, M1d2, M1d3);
            fcol_d = fcol_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            finA_q  <= 1'b1;
            base_q  <= '0;
            fcol_q  <= '0;
            win_q   <= '0;
            vld_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            finA_q  <= finA_d;
            base_q  <= base_d;
            fcol_q  <= fcol_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign a1        = base_q + {8'd0, fcol_q};
    assign win       = win_q;
    assign win_valid = vld_q;
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign busy      = (state_q == PRIME0) || (state_q == PRIME1) || (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_win_reader.sv
// Bench for win_reader: frame-store model, random back-pressure, and a
// window reference computed directly from frame coordinates.
module tb_win_reader;

    localparam int IMG_W = 180;
    localparam int IMG_H = 320;
    localparam int DW    = 9;
    localparam int LIMIT = 90000;

    logic            clk = 1'b0;
    logic            rst;
    logic            finA;
    logic [15:0]     a1;
    logic [DW-1:0]   M1d1, M1d2, M1d3;
    logic [9*DW-1:0] win;
    logic            win_valid;
    logic            win_ready;
    logic [8:0]      win_row;
    logic [7:0]      win_col;
    logic            busy;
    logic            done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_xfer;
    bit          mode = 1'b0;
    int unsigned seed = 0;

    win_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk(clk), .rst(rst), .finA(finA), .a1(a1),
        .M1d1(M1d1), .M1d2(M1d2), .M1d3(M1d3),
        .win(win), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Frame contents: mode 0 is the low address bits, mode 1 a seeded hash.
    function automatic logic [DW-1:0] px(input int addr, input bit m, input int unsigned s);
        int unsigned h;
        h = 32'(addr);
        if (!m) return h[DW-1:0];
        h = (h * 32'd2654435761) ^ s;
        h = h ^ (h >> 13);
        return h[DW-1:0];
    endfunction

    assign M1d1 = px(int'(a1), mode, seed);
    assign M1d2 = px(int'(a1) + IMG_W, mode, seed);
    assign M1d3 = px(int'(a1) + 2 * IMG_W, mode, seed);

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = px((r - 1 + i) * IMG_W + (c - 1 + j), mode, seed);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 128'(win_valid), 128'(0));
        chk({tag, "_win"},   128'(win),       128'(0));
        chk({tag, "_a1"},    128'(a1),        128'(0));
        chk({tag, "_row"},   128'(win_row),   128'(0));
        chk({tag, "_col"},   128'(win_col),   128'(0));
        chk({tag, "_busy"},  128'(busy),      128'(0));
        chk({tag, "_done"},  128'(done),      128'(0));
    endtask

    // Starts a scan (finA must already be sampled low) and follows it until
    // window (stop_r, stop_c) is presented; returns with win_ready low.
    task automatic run_scan(input int stop_r, input int stop_c, input bit toggle);
        int r, c, gap, cyc, stall;
        bit hit, held;
        logic [15:0] a1_hold;
        logic [9*DW-1:0] win_hold;
        r = 1; c = 1; gap = 0; cyc = 0; stall = 5; hit = 0; held = 0;
        a1_hold = '0; win_hold = '0;
        n_xfer = 0;
        win_ready = 1'b0;
        finA = 1'b1;
        step();
        chk("start_busy", 128'(busy), 128'(1));
        for (int i = 0; i < 3; i++) begin
            chk("latency_invalid", 128'(win_valid), 128'(0));
            step();
        end
        chk("latency_valid", 128'(win_valid), 128'(1));
        while (!hit && cyc < LIMIT) begin
            if (toggle && cyc == 1000) finA = 1'b0;
            if (toggle && cyc == 1003) finA = 1'b1;
            if (win_valid) begin
                chk("gap_len", 128'(gap), 128'(0));
                chk("row", 128'(win_row), 128'(r));
                chk("col", 128'(win_col), 128'(c));
                chk("win", 128'(win), 128'(exp_win(r, c)));
                chk("busy_run", 128'(busy), 128'(1));
                if (held) begin
                    chk("hold_a1", 128'(a1), 128'(a1_hold));
                    chk("hold_win", 128'(win), 128'(win_hold));
                end
                if (r == stop_r && c == stop_c) begin
                    hit = 1;
                    win_ready = 1'b0;
                end else begin
                    if (stall > 0) begin
                        win_ready = 1'b0;
                        stall--;
                    end else begin
                        win_ready = ($urandom_range(15) != 0);
                    end
                    held = !win_ready;
                    a1_hold = a1;
                    win_hold = win;
                    if (win_ready) begin
                        n_xfer++;
                        if (c == IMG_W - 2) begin
                            c = 1; r++; gap = 3;
                        end else begin
                            c++;
                        end
                    end
                    step();
                    cyc++;
                end
            end else begin
                chk("busy_gap", 128'(busy), 128'(1));
                if (gap > 0) gap--;
                else chk("no_bubble", 128'(win_valid), 128'(1));
                held = 0;
                step();
                cyc++;
            end
        end
        n_cmp++;
        assert (hit) else begin
            n_bad++;
            $error("FAIL scan_timeout: observed cycles %0d expected window (%0d,%0d)", cyc, stop_r, stop_c);
        end
    endtask

    initial begin
        rst = 1'b1;
        finA = 1'b1;
        win_ready = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("no_start_high_valid", 128'(win_valid), 128'(0));
            chk("no_start_high_busy", 128'(busy), 128'(0));
            step();
        end
        finA = 1'b0;
        step();

        // Full frame, address-pattern memory, with back-pressure and a finA blip.
        mode = 1'b0;
        run_scan(IMG_H - 2, IMG_W - 2, 1'b1);
        chk("last_row", 128'(win_row), 128'(318));
        chk("last_col", 128'(win_col), 128'(178));
        chk("last_k0", 128'(win[DW-1:0]), 128'(405));
        win_ready = 1'b1;
        n_xfer++;
        step();
        chk("xfer_count", 128'(n_xfer), 128'(56604));
        chk("end_valid", 128'(win_valid), 128'(0));
        chk("end_done", 128'(done), 128'(1));
        chk("end_busy", 128'(busy), 128'(0));
        win_ready = 1'b0;
        repeat (3) step();
        chk("done_hold", 128'(done), 128'(1));
        finA = 1'b0;
        step();
        chk("idle_done", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));

        // Hashed memory, reset in the middle of the scan.
        mode = 1'b1;
        seed = $urandom;
        run_scan(5, 40, 1'b0);
        rst = 1'b1;
        step();
        check_idle_outputs("midreset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("post_reset_valid", 128'(win_valid), 128'(0));
            chk("post_reset_busy", 128'(busy), 128'(0));
            step();
        end
        finA = 1'b0;
        step();
        run_scan(1, 6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/win_reader.md
WIN_READER -- requirements
Module: win_reader

Interface
REQ-001 Parameters SHALL be: IMG_W, 180, image width in pixels; IMG_H, 320, image height in rows; DW, 9, pixel width in bits.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 finA  in  1  frame-store write-complete flag, level.
REQ-005 a1  out  16  frame-store read address, top pixel of the fetched column.
REQ-006 M1d1/M1d2/M1d3  in  DW each  combinational frame-store data at a1, a1+IMG_W, a1+2*IMG_W.
REQ-007 win  out  9*DW  3x3 window, row-major, pixel k=3*row+col at win[DW*k +: DW], k=0 top-left.
REQ-008 win_valid  out  1  window valid.
REQ-009 win_ready  in  1  downstream accepts window.
REQ-010 win_row  out  9  centre row of win; win_col  out  8  centre column of win.
REQ-011 busy  out  1  scan in progress; done  out  1  full frame scanned.

Function
REQ-012 Scan SHALL start on a finA rising edge, detected against a registered copy finA_q, only in IDLE.
REQ-013 Scan SHALL cover centres r=1..IMG_H-2 and c=1..IMG_W-2, row-major, each exactly once (56604 windows at defaults).
REQ-014 a1 SHALL equal (r-1)*IMG_W + fetch_col, built from registered counters, with no addition overflow at defaults.
REQ-015 FSM states SHALL be IDLE, PRIME0, PRIME1, RUN and DONE.
REQ-016 PRIME0 SHALL capture column 0 of the current row band and go to PRIME1; PRIME1 SHALL capture column 1 and go to RUN.
REQ-017 Column capture SHALL shift win left one column and load {M1d1,M1d2,M1d3} into the right column (k=2,5,8).
REQ-018 Entering RUN SHALL capture column 2 and set win_valid=1 at the same edge.
REQ-019 In RUN, a transfer SHALL occur when win_valid && win_ready.
REQ-020 A transfer with c<IMG_W-2 SHALL capture column c+2 at the same edge, giving back-to-back windows with no bubble.
REQ-021 A transfer with c=IMG_W-2 and r<IMG_H-2 SHALL clear win_valid and go to PRIME0 for row r+1, giving 3 invalid cycles.
REQ-022 A transfer of the last window (r=IMG_H-2, c=IMG_W-2) SHALL clear win_valid and go to DONE.
REQ-023 While win_valid && !win_ready, win, win_row, win_col and a1 SHALL hold stable and no fetch SHALL occur.
REQ-024 busy SHALL be 1 in PRIME0, PRIME1 and RUN, else 0; done SHALL be 1 only in DONE.
REQ-025 DONE SHALL return to IDLE when finA is sampled 0; a new rising edge then restarts from r=1, c=1.
REQ-026 A finA edge while busy SHALL be ignored.
REQ-027 First win_valid SHALL assert 3 cycles after the edge at which the finA rising edge is sampled.

Reset
REQ-028 rst SHALL force IDLE, win_valid=0, win=0, a1=0, win_row=0, win_col=0, busy=0, done=0 and finA_q=1, overriding all other events in that cycle.
REQ-029 Because finA_q resets to 1, finA held high through reset SHALL NOT start a scan; a low-then-high transition is required.
REQ-030 Reset mid-scan SHALL abandon the scan with no further win_valid until a new start.

Verification
REQ-031 Memory holds addr[8:0], win_ready=1, finA 0->1 -> after 3 cycles win_valid=1 with win_row=1, win_col=1, win k0..8 = 0,1,2,180,181,182,360,361,362.
REQ-032 Same setup, run to end -> exactly 56604 transfers; last has win_row=318, win_col=178, win k0=405; done=1 on the next cycle.
REQ-033 win_ready=0 for 5 cycles on window (1,1) -> win and a1 stable for the 5 cycles; the next window is (1,2) with no window skipped.
REQ-034 Row wrap: transfer of (1,178) -> win_valid=0 for 3 cycles, then (2,1) with k0=180.
REQ-035 Assert rst during window (5,40), with finA held high -> all outputs 0 and no start; finA 0 then 1 -> restart at (1,1).
REQ-036 Toggle finA low-high mid-scan -> scan order and count unchanged; finA low in DONE -> IDLE with done=0.
